// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer_pkg                                             |
// | Purpose  : Shared definitions for the fetch sequencer: control state       |
// |            encodings, opcode/funct constants, instruction classes and the  |
// |            opcode decoder used during ID.                                  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fetch_sequencer_pkg;

  localparam int NUM_INSTR_DEFAULT = 14;
  localparam int PC_W_DEFAULT      = 8;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE  = 3'd0,
    CL_ALUI   = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_JUMP   = 3'd5,
    CL_JR     = 3'd6,
    CL_JAL    = 3'd7
  } class_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef struct packed {
    logic   valid;
    class_e cls;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d.valid = 1'b1;
    d.cls   = CL_RTYPE;
    case (instr[31:26])
      OP_RTYPE: d.cls = (instr[5:0] == FUNCT_JR) ? CL_JR : CL_RTYPE;
      OP_ADDIU: d.cls = CL_ALUI;
      OP_LW:    d.cls = CL_LOAD;
      OP_SW:    d.cls = CL_STORE;
      OP_BEQ,
      OP_BNE:   d.cls = CL_BRANCH;
      OP_J:     d.cls = CL_JUMP;
      OP_JAL:   d.cls = CL_JAL;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic needs_mem(input class_e c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

  function automatic logic needs_wb(input class_e c);
    return (c == CL_RTYPE) || (c == CL_ALUI) || (c == CL_LOAD) || (c == CL_JAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer_if                                              |
// | Purpose  : Bundle of the instruction-memory fetch interface and the        |
// |            sequencer status outputs.                                       |
// | Ports    : master (sequencer)  in : instr, rs_data, rt_data                |
// |                                out: state, pc, ir, ra_we, ra_data,         |
// |                                     retired, halted, illegal               |
// |            slave  (memory/env) mirror image of master                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);
  logic [31:0]     instr;
  logic [31:0]     rs_data;
  logic [31:0]     rt_data;
  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            ra_we;
  logic [31:0]     ra_data;
  logic [15:0]     retired;
  logic            halted;
  logic            illegal;

  modport master (
    input  instr, rs_data, rt_data,
    output state, pc, ir, ra_we, ra_data, retired, halted, illegal
  );

  modport slave (
    output instr, rs_data, rt_data,
    input  state, pc, ir, ra_we, ra_data, retired, halted, illegal
  );
endinterface
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : next_pc_unit                                                    |
// | Purpose  : Combinational redirect logic. Reports whether the current       |
// |            instruction redirects the PC and, if so, where to.              |
// | Ports    : pc_i      in  PC_W  current word index                          |
// |            ir_i      in  32    latched instruction                         |
// |            rs_data_i in  32    register value for ir[25:21]                |
// |            rt_data_i in  32    register value for ir[20:16]                |
// |            cls_i     in  3     instruction class                           |
// |            target_o  out PC_W  redirect target                             |
// |            taken_o   out 1     redirect instead of pc+1                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module next_pc_unit
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     ir_i,
  input  logic [31:0]     rs_data_i,
  input  logic [31:0]     rt_data_i,
  input  class_e          cls_i,
  output logic [PC_W-1:0] target_o,
  output logic            taken_o
);

  // Branch target computed at full word width, then truncated; this gives
  // the modulo-2^PC_W wrap for backward offsets past zero.
  logic [31:0] w_br_sum;
  assign w_br_sum = {{(32-PC_W){1'b0}}, pc_i} + 32'd1 + {{16{ir_i[15]}}, ir_i[15:0]};

  always_comb begin
    taken_o  = 1'b0;
    target_o = w_br_sum[PC_W-1:0];
    case (cls_i)
      CL_BRANCH: taken_o = (rs_data_i == rt_data_i) ^ (ir_i[31:26] == OP_BNE);
      CL_JUMP,
      CL_JAL: begin
        taken_o  = 1'b1;
        target_o = ir_i[PC_W-1:0];
      end
      CL_JR: begin
        taken_o  = 1'b1;
        target_o = rs_data_i[PC_W-1:0];
      end
      default: taken_o = 1'b0;
    endcase
  end

  logic w_unused;
  assign w_unused = ^{ir_i[25:16], w_br_sum[31:PC_W]};

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                                 |
// | Purpose  : Multi-cycle IF/ID/EX/MEM/WB control sequencer. Drives state and |
// |            pc to instruction memory, latches the instruction, walks the    |
// |            per-class state path, computes the next PC and halts when       |
// |            execution leaves the program or hits an undecodable opcode.     |
// | Ports    : clk  in  1   clock, posedge                                     |
// |            rst  in  1   synchronous active-high reset                      |
// |            bus  fetch_sequencer_if.master (instr/rs_data/rt_data in;       |
// |                 state/pc/ir/ra_we/ra_data/retired/halted/illegal out)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int NUM_INSTR = NUM_INSTR_DEFAULT,
  parameter int PC_W      = PC_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_sequencer_if.master     bus
);

  localparam logic [PC_W:0] C_NUM_INSTR = (PC_W+1)'(NUM_INSTR);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  class_e          cls_q, cls_d;
  logic [15:0]     retired_q, retired_d;
  logic            illegal_q, illegal_d;

  decode_t         w_dec;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic            w_taken;
  logic [PC_W-1:0] w_next_pc;
  logic            w_complete;
  logic            w_ra_we;

  assign w_dec     = decode_instr(bus.instr);
  assign w_pc_inc  = pc_q + PC_W'(1);
  assign w_next_pc = w_taken ? w_target : w_pc_inc;

  // Redirect logic always looks at the latched ir/class, never at instr.
  next_pc_unit #(
    .PC_W (PC_W)
  ) u_next_pc (
    .pc_i      (pc_q),
    .ir_i      (ir_q),
    .rs_data_i (bus.rs_data),
    .rt_data_i (bus.rt_data),
    .cls_i     (cls_q),
    .target_o  (w_target),
    .taken_o   (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IF;
      pc_q      <= '0;
      ir_q      <= '0;
      cls_q     <= CL_RTYPE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cls_d      = cls_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    w_complete = 1'b0;

    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        ir_d = bus.instr;
        if (w_dec.valid) begin
          cls_d   = w_dec.cls;
          state_d = ST_EX;
        end else begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end
      end
      ST_EX: begin
        if (needs_mem(cls_q))     state_d = ST_MEM;
        else if (needs_wb(cls_q)) state_d = ST_WB;
        else                      w_complete = 1'b1;
      end
      ST_MEM: begin
        if (needs_wb(cls_q)) state_d = ST_WB;
        else                 w_complete = 1'b1;
      end
      ST_WB:   w_complete = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    // Every class retires on the edge leaving its last state; the pc
    // update rides on the same edge (EX for branch/j/jr, WB for jal).
    if (w_complete) begin
      pc_d      = w_next_pc;
      retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
      state_d   = ({1'b0, w_next_pc} < C_NUM_INSTR) ? ST_IF : ST_HALT;
    end
  end

  assign w_ra_we     = (state_q == ST_WB) && (cls_q == CL_JAL);

  assign bus.state   = state_q;
  assign bus.pc      = pc_q;
  assign bus.ir      = ir_q;
  assign bus.ra_we   = w_ra_we;
  assign bus.ra_data = w_ra_we ? {{(32-PC_W){1'b0}}, w_pc_inc} : 32'd0;
  assign bus.retired = retired_q;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_sequencer                                              |
// | Purpose  : Self-checking bench for fetch_sequencer: directed scenarios     |
// |            followed by random instruction streams checked against an       |
// |            instruction-level reference model.                              |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam int NUM_INSTR = 14;
  localparam int PC_W      = 8;
  localparam int MASK      = (1 << PC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(
    .NUM_INSTR (NUM_INSTR),
    .PC_W      (PC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, at instruction granularity.
  int m_pc      = 0;
  int m_retired = 0;
  bit m_halted  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected state walk after ID, straight from the opcode table.
  function automatic bit model_path(input logic [31:0] ins, output int n, output int seq [0:2]);
    logic [5:0] op;
    op = ins[31:26];
    seq[0] = 2; seq[1] = 0; seq[2] = 0;
    n = 1;
    case (op)
      6'h00: if (ins[5:0] != 6'h08) begin n = 2; seq[1] = 4; end
      6'h09, 6'h03: begin n = 2; seq[1] = 4; end
      6'h23: begin n = 3; seq[1] = 3; seq[2] = 4; end
      6'h2B: begin n = 2; seq[1] = 3; end
      6'h04, 6'h05, 6'h02: n = 1;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic int model_next_pc(input int pc, input logic [31:0] ins,
                                       input logic [31:0] rs, input logic [31:0] rt);
    logic [5:0]  op;
    logic [15:0] imm;
    int          seq_pc;
    int          br_pc;
    op     = ins[31:26];
    imm    = ins[15:0];
    seq_pc = (pc + 1) & MASK;
    br_pc  = (pc + 1 + int'($signed(imm))) & MASK;
    case (op)
      6'h04:        return (rs == rt) ? br_pc : seq_pc;
      6'h05:        return (rs != rt) ? br_pc : seq_pc;
      6'h02, 6'h03: return int'(ins) & MASK;
      6'h00:        return (ins[5:0] == 6'h08) ? (int'(rs) & MASK) : seq_pc;
      default:      return seq_pc;
    endcase
  endfunction

  task automatic do_reset();
    bus.instr   = 32'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_retired = 0; m_halted = 1'b0;
    chk("rst_state",   32'(bus.state), 32'd0);
    chk("rst_pc",      32'(bus.pc),    32'd0);
    chk("rst_ir",      bus.ir,         32'd0);
    chk("rst_ra_we",   32'(bus.ra_we), 32'd0);
    chk("rst_ra_data", bus.ra_data,    32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    chk("rst_halted",  32'(bus.halted),  32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
  endtask

  // Runs one instruction from IF to completion, checking every cycle.
  task automatic exec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    int seq [0:2];
    int n;
    int npc;
    bit legal;
    bit is_jal;
    bit wb_jal;
    legal  = model_path(ins, n, seq);
    is_jal = (ins[31:26] == 6'h03);
    chk("if_state", 32'(bus.state), 32'd0);
    chk("if_pc",    32'(bus.pc),    32'(m_pc));
    bus.instr   = ins;
    bus.rs_data = rs;
    bus.rt_data = rt;
    @(negedge clk);
    chk("id_state", 32'(bus.state), 32'd1);
    if (!legal) begin
      @(negedge clk);
      m_halted = 1'b1;
      chk("ill_state",   32'(bus.state),   32'd5);
      chk("ill_flag",    32'(bus.illegal), 32'd1);
      chk("ill_halted",  32'(bus.halted),  32'd1);
      chk("ill_pc",      32'(bus.pc),      32'(m_pc));
      chk("ill_retired", 32'(bus.retired), 32'(m_retired));
      return;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wb_jal = is_jal && (seq[i] == 4);
      chk("path_state", 32'(bus.state), 32'(seq[i]));
      if (i == 0) chk("ir", bus.ir, ins);
      chk("ra_we", 32'(bus.ra_we), 32'(wb_jal));
      if (wb_jal) chk("ra_data", bus.ra_data, 32'((m_pc + 1) & MASK));
    end
    npc = model_next_pc(m_pc, ins, rs, rt);
    @(negedge clk);
    m_pc = npc;
    if (m_retired < 65535) m_retired++;
    m_halted = (npc >= NUM_INSTR);
    chk("done_state",   32'(bus.state),   m_halted ? 32'd5 : 32'd0);
    chk("done_pc",      32'(bus.pc),      32'(m_pc));
    chk("done_retired", 32'(bus.retired), 32'(m_retired));
    chk("done_halted",  32'(bus.halted),  32'(m_halted));
  endtask

  task automatic goto_pc(input int p);
    exec(32'h0800_0000 | 32'(p), 32'd0, 32'd0);
  endtask

  task automatic gen_random(output logic [31:0] ins, output logic [31:0] rs, output logic [31:0] rt);
    logic [31:0] f;
    logic [5:0]  funct;
    logic [15:0] off;
    logic [7:0]  tgt;
    int          kind;
    f    = $urandom;
    kind = int'($urandom_range(0, 8));
    off  = 16'(int'($urandom_range(0, 16)) - 8);
    tgt  = 8'($urandom_range(0, 15));
    rs   = $urandom;
    rt   = ($urandom_range(0, 1) == 1) ? rs : $urandom;
    case (kind)
      0: begin
        funct = (f[5:0] == 6'h08) ? 6'h20 : f[5:0];
        ins = {6'h00, f[25:6], funct};
      end
      1: ins = {6'h09, f[25:0]};
      2: ins = {6'h23, f[25:0]};
      3: ins = {6'h2B, f[25:0]};
      4: ins = {6'h04, f[25:16], off};
      5: ins = {6'h05, f[25:16], off};
      6: ins = {6'h02, f[25:8], tgt};
      7: ins = {6'h03, f[25:8], tgt};
      default: begin
        ins = {6'h00, f[25:6], 6'h08};
        rs  = {rs[31:8], tgt};
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r_ins, r_rs, r_rt;
    bus.instr   = 32'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    @(negedge clk);
    do_reset();

    // Directed scenarios.
    exec(32'h2402_0000, 32'd0, 32'd0);      // addiu at pc 0 -> pc 1
    goto_pc(12);
    exec(32'h8C01_000A, 32'd0, 32'd0);      // lw at 12 -> 13
    goto_pc(3);
    exec(32'h1080_0008, 32'd0, 32'd0);      // beq taken -> 12
    goto_pc(3);
    exec(32'h1080_0008, 32'd1, 32'd0);      // beq not taken -> 4
    goto_pc(10);
    exec(32'h1480_FFFB, 32'd1, 32'd0);      // bne taken -> 6
    goto_pc(13);
    exec(32'h0C00_0000, 32'd0, 32'd0);      // jal -> ra 14, pc 0
    exec(32'h03E0_0008, 32'd14, 32'd0);     // jr 14 -> halt
    repeat (3) @(negedge clk);
    chk("halt_hold_state", 32'(bus.state), 32'd5);
    chk("halt_hold_pc",    32'(bus.pc),    32'd14);

    // Backward branch wrapping past zero.
    do_reset();
    exec(32'h1000_FFFE, 32'd7, 32'd7);

    // Undecodable opcode.
    do_reset();
    exec(32'h2402_0000, 32'd0, 32'd0);
    exec(32'hFC00_0000, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("ill_hold_state", 32'(bus.state),   32'd5);
    chk("ill_hold_flag",  32'(bus.illegal), 32'd1);

    // Reset while in MEM of a lw.
    do_reset();
    exec(32'h2402_0000, 32'd0, 32'd0);
    bus.instr = 32'h8C01_000A;
    repeat (3) @(negedge clk);
    chk("mem_state", 32'(bus.state), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_retired = 0; m_halted = 1'b0;
    chk("mrst_state",   32'(bus.state),   32'd0);
    chk("mrst_pc",      32'(bus.pc),      32'd0);
    chk("mrst_retired", 32'(bus.retired), 32'd0);

    // Random instruction streams.
    for (int k = 0; k < 400; k++) begin
      if (m_halted) do_reset();
      gen_random(r_ins, r_rs, r_rt);
      exec(r_ins, r_rs, r_rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control sequencer at the consuming end of the instruction-memory fetch interface.
- Drives the `state` and `pc` lines that the instruction memory samples, and captures the returned 32-bit instruction into an instruction register.
- Decodes the opcode to pick the per-instruction state path: IF, ID, EX, then optionally MEM and/or WB.
- Computes the next PC (sequential, branch, jump, jump-register, jump-and-link) and stops in HALT when execution leaves the program.

Parameters:
- NUM_INSTR, 14: number of valid instruction words; any next PC >= NUM_INSTR halts.
- PC_W, 8: PC width. PC is a word index, not a byte address.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from instruction memory; valid during ID, held until the next IF edge.
- rs_data  in  32  register value selected by ir[25:21]; valid during EX.
- rt_data  in  32  register value selected by ir[20:16]; valid during EX.
- state  out  3  current control state; encodings IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- pc  out  PC_W  word index of the instruction being processed.
- ir  out  32  latched instruction; loaded at the end of ID.
- ra_we  out  1  link-register write strobe; high only in WB of jal.
- ra_data  out  32  link value {24'b0, pc+1}; meaningful only when ra_we=1.
- retired  out  16  count of completed instructions.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when HALT is entered because of an undecodable opcode.

Behaviour:
- Reset values: state=IF, pc=0, ir=0, ra_we=0, ra_data=0, retired=0, halted=0, illegal=0.
- Reset applies on any cycle, including mid-instruction and while in HALT.
- Memory latency: the instruction memory registers instr at the posedge ending IF, so the sequencer samples instr only during ID. IF→ID is unconditional.
- ID: ir<=instr. Decode opcode=instr[31:26]:
  - 0x00 with funct 0x08 (jr): EX → IF.
  - 0x00 other (R-type): EX → WB → IF.
  - 0x09 (addiu): EX → WB → IF.
  - 0x23 (lw): EX → MEM → WB → IF.
  - 0x2B (sw): EX → MEM → IF.
  - 0x04 (beq), 0x05 (bne), 0x02 (j): EX → IF.
  - 0x03 (jal): EX → WB → IF.
  - Any other opcode: ID → HALT with illegal<=1; pc unchanged; retired not incremented.
- The path is held in an internal class register, so EX/MEM/WB decisions use ir/class, never instr.
- Next PC, all arithmetic mod 2^PC_W:
  - Default: pc+1.
  - beq/bne: taken when (rs_data==rt_data) xor bne; target = pc+1+sext(ir[15:0]), truncated to PC_W.
  - j/jal: target = ir[PC_W-1:0].
  - jr: target = rs_data[PC_W-1:0].
- Branch/jump decisions and the pc update happen at the posedge ending EX.
- jal: pc updates at the end of WB. During WB, ra_we=1 and ra_data={24'b0, pc+1} using the old pc.
- All other classes: pc<=pc+1 on the edge leaving their final state.
- Completion edge: retired increments (saturating at 0xFFFF).
  - If next pc < NUM_INSTR: next state is IF.
  - Otherwise: next state is HALT, halted=1, and pc holds the out-of-range next value.
- HALT is sticky until rst. state=HALT means memory does not fetch, and all outputs hold.
- Branch wrap: a backward offset past 0 wraps to a high index (e.g. pc=0, offset -2 → 255), which then halts when 255 >= NUM_INSTR.

Decomposition:
- Shared defs header holds:
  - state encodings IF/ID/EX/MEM/WB/HALT;
  - opcode/funct constants;
  - NUM_INSTR default;
  - class encoding (RTYPE, ALUI, LOAD, STORE, BRANCH, JUMP, JR, JAL).
- One natural sub-module: `next_pc_unit`, purely combinational. Inputs pc, ir, rs_data, rt_data, class; outputs target and taken.
- The FSM, ir, counters and flags stay in fetch_sequencer.

Test Plan:
- Reset → IF, pc=0. Then feed addiu 0x24020000 in ID: state sequence 0,1,2,4,0; pc=1 after WB; retired=1.
- lw 0x8C01000A at pc=12: sequence IF,ID,EX,MEM,WB,IF (5 cycles); pc=13.
- beq 0x10800008 at pc=3:
  - rs=rt=0: pc=12 after EX, 3 cycles total.
  - rs=1, rt=0: pc=4.
- bne 0x1480FFFB at pc=10, rs=1, rt=0: pc=6.
- jal 0x0C000000 at pc=13: WB shows ra_we=1, ra_data=14; then pc=0.
- jr 0x03E00008 with rs_data=14 (NUM_INSTR=14): state=HALT, halted=1, pc=14.
- Opcode 0x3F: HALT with illegal=1, retired unchanged.
- Assert rst in MEM of a lw: next cycle state=IF, pc=0, retired=0.
